blob_fifo: RTL and testbench



---
 rtl/blob_fifo.sv | 111 +++++++++++
 tb/tb_blob_fifo.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blob_fifo.sv
// blob_fifo: synchronous first-word-fall-through FIFO for blob streams.
// Each entry holds a data word plus its end-of-packet bit. The input side
// deasserts blob_din_rdy MARGIN entries before full so an upstream with
// in-flight writes never overruns; a write that still arrives while full is
// dropped and latches the sticky overflow flag.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   blob_din, blob_din_eop    write word and its end-of-packet bit
//   blob_din_en               write strobe
//   blob_din_rdy              write permission (count < DEPTH-MARGIN)
//   blob_dout, blob_dout_eop  head word; eop qualified by blob_dout_en
//   blob_dout_rdy             downstream accepts the head word
//   blob_dout_en              read fire
//   count, pkt_cnt            stored entries / stored entries with eop=1
//   overflow                  sticky, write attempted while full
module blob_fifo #(
    parameter int unsigned WIDTH  = 512,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned MARGIN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  blob_din,
    output logic              blob_din_rdy,
    input  logic              blob_din_en,
    input  logic              blob_din_eop,
    output logic [WIDTH-1:0]  blob_dout,
    input  logic              blob_dout_rdy,
    output logic              blob_dout_en,
    output logic              blob_dout_eop,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W:0]   pkt_cnt,
    output logic              overflow
);

    localparam logic [ADDR_W:0] CntFull  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CntLimit = (ADDR_W + 1)'(DEPTH - MARGIN);

    logic [WIDTH:0]    mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   pkt_cnt_q, pkt_cnt_d;
    logic              overflow_q;

    logic              full, empty;
    logic              wr_fire, rd_fire;
    logic [WIDTH:0]    head;
    logic              pkt_inc, pkt_dec;

    assign full  = (count_q == CntFull);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Full is judged on the current count, so a same-cycle read never
    // makes room for a write into a full FIFO.
    assign wr_fire = blob_din_en & ~full & ~rst;
    assign rd_fire = ~empty & blob_dout_rdy & ~rst;

    assign blob_din_rdy  = ~rst & (count_q < CntLimit);
    assign blob_dout_en  = rd_fire;
    assign blob_dout     = head[WIDTH-1:0];
    assign blob_dout_eop = head[WIDTH] & rd_fire;
    assign count         = count_q;
    assign pkt_cnt       = pkt_cnt_q;
    assign overflow      = overflow_q;

    assign pkt_inc = wr_fire & blob_din_eop;
    assign pkt_dec = rd_fire & head[WIDTH];

    always_comb begin
        count_d = count_q;
        unique case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        unique case ({pkt_inc, pkt_dec})
            2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
            2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pkt_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q   <= count_d;
            pkt_cnt_q <= pkt_cnt_d;
            if (blob_din_en & full) overflow_q <= 1'b1;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[wr_ptr_q] <= {blob_din_eop, blob_din};
    end

endmodule

// File: tb/tb_blob_fifo.sv
// Testbench for blob_fifo: randomized traffic against a queue-based model
// of the stored words, plus scenario tasks for reset, fill/overflow,
// streaming and mid-packet reset.
module tb_blob_fifo;

    localparam int W = 64;
    localparam int D = 64;
    localparam int A = 6;
    localparam int M = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din = '0;
    logic         din_rdy;
    logic         din_en = 1'b0;
    logic         din_eop = 1'b0;
    logic [W-1:0] dout;
    logic         dout_rdy = 1'b0;
    logic         dout_en;
    logic         dout_eop;
    logic [A:0]   count;
    logic [A:0]   pkt_cnt;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    // Model: the words currently stored, head first, plus the sticky flag.
    logic [W:0] mq[$];
    bit         m_ovf = 1'b0;

    blob_fifo #(.WIDTH(W), .DEPTH(D), .ADDR_W(A), .MARGIN(M)) dut (
        .clk           (clk),
        .rst           (rst),
        .blob_din      (din),
        .blob_din_rdy  (din_rdy),
        .blob_din_en   (din_en),
        .blob_din_eop  (din_eop),
        .blob_dout     (dout),
        .blob_dout_rdy (dout_rdy),
        .blob_dout_en  (dout_en),
        .blob_dout_eop (dout_eop),
        .count         (count),
        .pkt_cnt       (pkt_cnt),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    function automatic int m_pkt();
        int c = 0;
        foreach (mq[i]) c += int'(mq[i][W]);
        return c;
    endfunction

    function automatic bit m_en();
        return !rst && mq.size() > 0 && dout_rdy;
    endfunction

    function automatic logic [W-1:0] rnd_word();
        return {$urandom, $urandom};
    endfunction

    // Apply the model's rule for the current inputs, then advance one clock.
    task automatic cycle();
        int n;
        bit rd;
        bit wr;
        n = mq.size();
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            rd = (n > 0) && dout_rdy;
            wr = din_en && (n < D);
            if (din_en && n == D) m_ovf = 1'b1;
            if (rd) void'(mq.pop_front());
            if (wr) mq.push_back({din_eop, din});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; din_en = 1'b0; din_eop = 1'b0; dout_rdy = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; din_en = 1'b0; dout_rdy = 1'b1;
        cycle();
        #1;
        checks++;
        if (din_rdy !== 1'b0 || dout_en !== 1'b0 || dout_eop !== 1'b0) begin
            errors++;
            $display("FAIL reset_during rdy=%b en=%b eop=%b required 0 0 0",
                     din_rdy, dout_en, dout_eop);
        end
        cycle();
        rst = 1'b0;
        #1;
        checks++;
        if (din_rdy !== 1'b1 || dout_en !== 1'b0 || dout_eop !== 1'b0 ||
            count !== '0 || pkt_cnt !== '0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_after rdy=%b en=%b eop=%b cnt=%0d pkt=%0d ovf=%b required 1 0 0 0 0 0",
                     din_rdy, dout_en, dout_eop, count, pkt_cnt, overflow);
        end
    endtask

    task automatic test_packet();
        logic [W-1:0] words[5];
        int nrx = 0;
        do_reset();
        foreach (words[i]) words[i] = rnd_word();
        dout_rdy = 1'b1;
        for (int c = 0; c < 8; c++) begin
            din_en  = (c < 5);
            din     = (c < 5) ? words[c] : '0;
            din_eop = (c == 4);
            #1;
            checks++;
            if (dout_en !== ((c >= 1 && c <= 5) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL pkt_en cyc=%0d got %b required %b", c, dout_en, (c >= 1 && c <= 5));
            end
            if (dout_en === 1'b1 && nrx < 5) begin
                checks++;
                if (dout !== words[nrx] || dout_eop !== (nrx == 4)) begin
                    errors++;
                    $display("FAIL pkt_word %0d got %h/%b required %h/%b",
                             nrx, dout, dout_eop, words[nrx], (nrx == 4));
                end
                nrx++;
            end
            checks++;
            if (pkt_cnt !== 7'(m_pkt())) begin
                errors++;
                $display("FAIL pkt_cnt cyc=%0d got %0d required %0d", c, pkt_cnt, m_pkt());
            end
            cycle();
        end
        din_en = 1'b0;
    endtask

    task automatic fill_to_full();
        dout_rdy = 1'b0;
        din_eop  = 1'b0;
        for (int i = 0; i < D; i++) begin
            din_en = 1'b1;
            din = rnd_word();
            cycle();
        end
        din_en = 1'b0;
    endtask

    task automatic test_fill();
        int trailing = 0;
        bit seen_drop = 0;
        do_reset();
        dout_rdy = 1'b0;
        din_eop  = 1'b0;
        for (int c = 0; c < 100 && trailing < M; c++) begin
            #1;
            checks++;
            if (din_rdy !== (mq.size() < D - M)) begin
                errors++;
                $display("FAIL fill_rdy cnt=%0d got %b required %b", mq.size(), din_rdy,
                         (mq.size() < D - M));
            end
            if (din_rdy !== 1'b1) begin
                if (!seen_drop) begin
                    seen_drop = 1;
                    checks++;
                    if (count !== 7'(D - M)) begin
                        errors++;
                        $display("FAIL fill_drop_cnt got %0d required %0d", count, D - M);
                    end
                end
                trailing++;
            end
            din_en = 1'b1;
            din = rnd_word();
            cycle();
        end
        din_en = 1'b0;
        #1;
        checks++;
        if (count !== 7'(D) || overflow !== 1'b0 || din_rdy !== 1'b0) begin
            errors++;
            $display("FAIL fill_full cnt=%0d ovf=%b rdy=%b required %0d 0 0",
                     count, overflow, din_rdy, D);
        end
        din_en = 1'b1;
        din = rnd_word();
        cycle();
        din_en = 1'b0;
        #1;
        checks++;
        if (count !== 7'(D) || overflow !== 1'b1) begin
            errors++;
            $display("FAIL fill_overflow cnt=%0d ovf=%b required %0d 1", count, overflow, D);
        end
    endtask

    task automatic test_full_rw();
        logic [W-1:0] tag;
        logic [W-1:0] last;
        do_reset();
        fill_to_full();
        tag = 64'hDEAD_BEEF_0BAD_F00D;
        din_en = 1'b1; din = tag; dout_rdy = 1'b1;
        cycle();
        din_en = 1'b0;
        #1;
        checks++;
        if (count !== 7'(D - 1) || overflow !== 1'b1) begin
            errors++;
            $display("FAIL full_rw cnt=%0d ovf=%b required %0d 1", count, overflow, D - 1);
        end
        last = '0;
        for (int c = 0; c < D + 4; c++) begin
            #1;
            if (m_en()) begin
                checks++;
                if (dout_en !== 1'b1 || dout !== mq[0][W-1:0]) begin
                    errors++;
                    $display("FAIL full_rw_drain en=%b got %h required %h", dout_en, dout,
                             mq[0][W-1:0]);
                end
                last = dout;
            end
            cycle();
        end
        checks++;
        if (count !== '0 || last === tag) begin
            errors++;
            $display("FAIL full_rw_dropped cnt=%0d last=%h required 0 and not %h", count, last, tag);
        end
    endtask

    task automatic test_stream();
        int max_cnt = 0;
        do_reset();
        dout_rdy = 1'b1;
        din_eop  = 1'b0;
        for (int c = 0; c < 201; c++) begin
            din_en = (c < 200);
            din = rnd_word();
            #1;
            if (int'(count) > max_cnt) max_cnt = int'(count);
            checks++;
            if (dout_en !== ((c >= 1) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL stream_en cyc=%0d got %b required %b", c, dout_en, (c >= 1));
            end
            if (m_en()) begin
                checks++;
                if (dout !== mq[0][W-1:0]) begin
                    errors++;
                    $display("FAIL stream_data cyc=%0d got %h required %h", c, dout, mq[0][W-1:0]);
                end
            end
            cycle();
        end
        din_en = 1'b0;
        checks++;
        if (max_cnt > 1 || count !== '0) begin
            errors++;
            $display("FAIL stream_count max=%0d end=%0d required <=1 and 0", max_cnt, count);
        end
    endtask

    task automatic test_random();
        logic [W:0] sent[$];
        int ntx = 0;
        int nrx = 0;
        int len;
        do_reset();
        for (int p = 0; p < 10; p++) begin
            len = $urandom_range(17, 1);
            for (int i = 0; i < len; i++) sent.push_back({(i == len - 1), rnd_word()});
        end
        for (int c = 0; c < 4000 && nrx < sent.size(); c++) begin
            dout_rdy = ($urandom_range(2, 0) != 0);
            din_en = (ntx < sent.size()) && din_rdy && ($urandom_range(3, 0) != 0);
            din = din_en ? sent[ntx][W-1:0] : '0;
            din_eop = din_en ? sent[ntx][W] : 1'b0;
            #1;
            checks++;
            if (dout_en !== m_en() || pkt_cnt !== 7'(m_pkt()) || count !== 7'(mq.size())) begin
                errors++;
                $display("FAIL rand_state cyc=%0d en=%b pkt=%0d cnt=%0d required %b %0d %0d",
                         c, dout_en, pkt_cnt, count, m_en(), m_pkt(), mq.size());
            end
            if (dout_en === 1'b1) begin
                checks++;
                if ({dout_eop, dout} !== sent[nrx]) begin
                    errors++;
                    $display("FAIL rand_word %0d got %b/%h required %b/%h", nrx, dout_eop, dout,
                             sent[nrx][W], sent[nrx][W-1:0]);
                end
                nrx++;
            end
            if (din_en) ntx++;
            cycle();
        end
        din_en = 1'b0;
        checks++;
        if (nrx != sent.size()) begin
            errors++;
            $display("FAIL rand_timeout received %0d required %0d", nrx, sent.size());
        end
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] words[3];
        int nrx = 0;
        do_reset();
        dout_rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            din_en = 1'b1; din = rnd_word(); din_eop = (i == 7 || i == 15);
            cycle();
        end
        din_en = 1'b0; din_eop = 1'b0;
        #1;
        checks++;
        if (count !== 7'd20 || pkt_cnt !== 7'd2) begin
            errors++;
            $display("FAIL midrst_pre cnt=%0d pkt=%0d required 20 2", count, pkt_cnt);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        dout_rdy = 1'b1;
        #1;
        checks++;
        if (count !== '0 || pkt_cnt !== '0 || dout_en !== 1'b0) begin
            errors++;
            $display("FAIL midrst_post cnt=%0d pkt=%0d en=%b required 0 0 0", count, pkt_cnt, dout_en);
        end
        foreach (words[i]) words[i] = rnd_word();
        for (int c = 0; c < 6; c++) begin
            din_en = (c < 3);
            din = (c < 3) ? words[c] : '0;
            din_eop = (c == 2);
            #1;
            if (dout_en === 1'b1) begin
                checks++;
                if (nrx >= 3 || dout !== words[nrx] || dout_eop !== (nrx == 2)) begin
                    errors++;
                    $display("FAIL midrst_word %0d got %h/%b", nrx, dout, dout_eop);
                end
                nrx++;
            end
            cycle();
        end
        din_en = 1'b0;
        checks++;
        if (nrx != 3) begin
            errors++;
            $display("FAIL midrst_count received %0d required 3", nrx);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_packet();
        test_fill();
        test_full_rw();
        test_stream();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
